// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter that shares one combinational 8-bit ALU among NREQ
// requesters. An accepted operation is held in registers that drive the ALU,
// the ALU result is captured one cycle later, and it is returned with the
// requester ID over a valid/ready response channel.
//
// Optional feature: define ALU_ARB_STATS_EN to add the stat_clr input and the
// saturating stat_ops / stat_ovf counters.
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   // requester side
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]   req_cin,
   input  logic [3*NREQ-1:0] req_s,
   // ALU side
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic              alu_cin,
   output logic [2:0]        alu_s,
   input  logic [7:0]        alu_data,
   input  logic              alu_cout,
   input  logic              alu_ovf,
   // response side
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_data,
   output logic              rsp_cout,
   output logic              rsp_ovf
`ifdef ALU_ARB_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [15:0]       stat_ops,
   output logic [15:0]       stat_ovf
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Reduce a value in [0, 2*NREQ-2] modulo NREQ without a divider.
   function automatic logic [IDW-1:0] f_wrap(input logic [IDW:0] v);
      logic [IDW:0] t;
      t = (v >= (IDW+1)'(NREQ)) ? v - (IDW+1)'(NREQ) : v;
      return t[IDW-1:0];
   endfunction

   state_t         r_state;
   state_t         w_state_nxt;
   logic [IDW-1:0] r_ptr;

   // latched operation (drives the ALU)
   logic [7:0]     r_op_a;
   logic [7:0]     r_op_b;
   logic           r_op_cin;
   logic [2:0]     r_op_s;
   logic [IDW-1:0] r_op_id;

   // captured result
   logic           r_rsp_valid;
   logic [IDW-1:0] r_rsp_id;
   logic [7:0]     r_rsp_data;
   logic           r_rsp_cout;
   logic           r_rsp_ovf;

   // per-requester views of the flattened payload buses
   logic [7:0]     w_a   [NREQ];
   logic [7:0]     w_b   [NREQ];
   logic [2:0]     w_s   [NREQ];

   logic           w_win_vld;
   logic [IDW-1:0] w_win_idx;
   logic           w_req_hs;
   logic           w_rsp_hs;

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign w_a[g] = req_a[g*8 +: 8];
      assign w_b[g] = req_b[g*8 +: 8];
      assign w_s[g] = req_s[g*3 +: 3];
   end

   // Round-robin pick: scan from the far end back towards the pointer so the
   // last hit, i.e. the one closest to the pointer, wins.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_win_vld = 1'b0;
      w_win_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[f_wrap({1'b0, r_ptr} + (IDW+1)'(k))]) begin
            w_win_vld = 1'b1;
            w_win_idx = f_wrap({1'b0, r_ptr} + (IDW+1)'(k));
         end
      end
   end

   assign w_req_hs = (r_state == IDLE) && w_win_vld;
   assign w_rsp_hs = r_rsp_valid && rsp_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         // NOTE: state updates use non-blocking assignments so every register
         // samples values from before the edge, independent of block order.
         r_state <= w_state_nxt;
      end
   end

   // Next-state and grant decode; grants are only issued from IDLE and are
   // held off while reset is asserted so all outputs read as zero.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      case (r_state)
         IDLE: begin
            if (w_win_vld) begin
               req_ready[w_win_idx] = rst_n;
               w_state_nxt          = EXEC;
            end
         end
         EXEC: w_state_nxt = RESP;
         RESP: begin
            if (w_rsp_hs) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Pointer and operation latch, updated on the request handshake only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr    <= '0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_op_cin <= 1'b0;
         r_op_s   <= '0;
         r_op_id  <= '0;
      end else if (w_req_hs) begin
         r_ptr    <= f_wrap({1'b0, w_win_idx} + (IDW+1)'(1));
         r_op_a   <= w_a[w_win_idx];
         r_op_b   <= w_b[w_win_idx];
         r_op_cin <= req_cin[w_win_idx];
         r_op_s   <= w_s[w_win_idx];
         r_op_id  <= w_win_idx;
      end
   end

   // Result capture at the end of EXEC; valid drops on the response handshake
   // while the payload keeps its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_rsp_cout  <= 1'b0;
         r_rsp_ovf   <= 1'b0;
      end else if (r_state == EXEC) begin
         r_rsp_valid <= 1'b1;
         r_rsp_id    <= r_op_id;
         r_rsp_data  <= alu_data;
         r_rsp_cout  <= alu_cout;
         r_rsp_ovf   <= alu_ovf;
      end else if (w_rsp_hs) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign alu_a     = r_op_a;
   assign alu_b     = r_op_b;
   assign alu_cin   = r_op_cin;
   assign alu_s     = r_op_s;

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign rsp_cout  = r_rsp_cout;
   assign rsp_ovf   = r_rsp_ovf;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] r_stat_ops;
   logic [15:0] r_stat_ovf;

   // Saturating operation / overflow counters; a clear beats a coincident
   // handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_ops <= '0;
         r_stat_ovf <= '0;
      end else if (stat_clr) begin
         r_stat_ops <= '0;
         r_stat_ovf <= '0;
      end else if (w_rsp_hs) begin
         if (r_stat_ops != 16'hFFFF) begin
            r_stat_ops <= r_stat_ops + 16'd1;
         end
         if (r_rsp_ovf && (r_stat_ovf != 16'hFFFF)) begin
            r_stat_ovf <= r_stat_ovf + 16'd1;
         end
      end
   end

   assign stat_ops = r_stat_ops;
   assign stat_ovf = r_stat_ovf;
`endif

   // Interface properties: at most one grant, grants only from IDLE, and the
   // response payload holds still under backpressure.
   a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));

   a_ready_idle_only : assert property (@(posedge clk) disable iff (!rst_n)
      (req_ready != '0) |-> (r_state == IDLE));

   a_rsp_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=>
         (rsp_valid && $stable({rsp_id, rsp_data, rsp_cout, rsp_ovf})));

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter with NREQ=4 and an adder stub ALU.
// Requesters are modelled as pending operations; the reference computes the
// expected grant from the round-robin rule, the expected result with integer
// arithmetic, and the expected response timing from the transaction rules.
// Define ALU_ARB_STATS_EN for both files to exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [8*NREQ-1:0] req_a = '0;
   logic [8*NREQ-1:0] req_b = '0;
   logic [NREQ-1:0]   req_cin = '0;
   logic [3*NREQ-1:0] req_s = '0;
   logic [7:0]        alu_a;
   logic [7:0]        alu_b;
   logic              alu_cin;
   logic [2:0]        alu_s;
   logic [7:0]        alu_data;
   logic              alu_cout;
   logic              alu_ovf;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [IDW-1:0]    rsp_id;
   logic [7:0]        rsp_data;
   logic              rsp_cout;
   logic              rsp_ovf;
`ifdef ALU_ARB_STATS_EN
   logic              stat_clr = 1'b0;
   logic [15:0]       stat_ops;
   logic [15:0]       stat_ovf;
`endif

   alu_arbiter #(.NREQ(NREQ)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_s     (req_s),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_cin   (alu_cin),
      .alu_s     (alu_s),
      .alu_data  (alu_data),
      .alu_cout  (alu_cout),
      .alu_ovf   (alu_ovf),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf)
`ifdef ALU_ARB_STATS_EN
      ,
      .stat_clr  (stat_clr),
      .stat_ops  (stat_ops),
      .stat_ovf  (stat_ovf)
`endif
   );

   always #5 clk = ~clk;

   // Stub ALU: 8-bit add with carry, signed overflow from operand/result signs.
   always_comb begin
      {alu_cout, alu_data} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      alu_ovf = (alu_a[7] == alu_b[7]) && (alu_data[7] != alu_a[7]);
   end

   // ---------------------------------------------------------------- model --
   bit         pend [NREQ];
   logic [7:0] pa   [NREQ];
   logic [7:0] pb   [NREQ];
   logic       pc   [NREQ];
   logic [2:0] ps   [NREQ];

   int         m_stage;   // 0: free, 1: op accepted, 2: response outstanding
   int         m_ptr;
   int         e_a, e_b, e_c, e_s, e_id;
   int         e_rv, e_rid, e_data, e_cout, e_ovf;
   int         e_ops, e_ovfc;
   int         g_log [$];
   int         g_cyc [$];
   int         cyc;
   bit         drv_rdy = 1'b1;
   bit         drv_clr = 1'b0;

   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference ALU: integer sum, carry from the unsigned sum, overflow from
   // the signed sum leaving the 8-bit range. Returns {ovf, cout, data}.
   function automatic logic [9:0] ref_alu(input int a, input int b, input int c);
      int u;
      int s;
      int sa;
      int sb;
      u  = a + b + c;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      s  = sa + sb + c;
      return {(s > 127 || s < -128), (u > 255), 8'(u)};
   endfunction

   task automatic set_req(input int i, input int a, input int b, input int c, input int s);
      pend[i] = 1'b1;
      pa[i]   = 8'(a);
      pb[i]   = 8'(b);
      pc[i]   = 1'(c);
      ps[i]   = 3'(s);
   endtask

   // One clock cycle: drive at the falling edge, check, then advance the model
   // across the following rising edge.
   task automatic step();
      int         win;
      logic [3:0] exp_rdy;
      logic [9:0] res;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]       = pend[i];
         req_a[i*8 +: 8]    = pa[i];
         req_b[i*8 +: 8]    = pb[i];
         req_cin[i]         = pc[i];
         req_s[i*3 +: 3]    = ps[i];
      end
      rsp_ready = drv_rdy;
`ifdef ALU_ARB_STATS_EN
      stat_clr = drv_clr;
`endif
      #1;
      cyc++;
      win = -1;
      if (m_stage == 0) begin
         for (int k = 0; k < NREQ; k++) begin
            if (win < 0 && pend[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
         end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;

      check("req_ready", req_ready, exp_rdy);
      check("alu_op", {alu_a, alu_b, alu_cin, alu_s},
            {8'(e_a), 8'(e_b), 1'(e_c), 3'(e_s)});
      check("rsp_valid", rsp_valid, e_rv);
      check("rsp_payload", {rsp_id, rsp_data, rsp_cout, rsp_ovf},
            {2'(e_rid), 8'(e_data), 1'(e_cout), 1'(e_ovf)});
`ifdef ALU_ARB_STATS_EN
      check("stat_ops", stat_ops, e_ops);
      check("stat_ovf", stat_ovf, e_ovfc);
`endif

      case (m_stage)
         0: begin
            if (win >= 0) begin
               e_a = pa[win]; e_b = pb[win]; e_c = pc[win]; e_s = ps[win];
               e_id = win;
               m_ptr = (win + 1) % NREQ;
               pend[win] = 1'b0;
               g_log.push_back(win);
               g_cyc.push_back(cyc);
               m_stage = 1;
            end
         end
         1: begin
            res     = ref_alu(e_a, e_b, e_c);
            e_data  = res[7:0];
            e_cout  = res[8];
            e_ovf   = res[9];
            e_rid   = e_id;
            e_rv    = 1;
            m_stage = 2;
         end
         default: begin
            if (drv_rdy) begin
               e_rv    = 0;
               m_stage = 0;
               if (e_ops < 16'hFFFF) e_ops++;
               if (e_ovf != 0 && e_ovfc < 16'hFFFF) e_ovfc++;
            end
         end
      endcase
      if (drv_clr) begin
         e_ops  = 0;
         e_ovfc = 0;
      end
   endtask

   // Reset for one cycle starting at a falling edge; outputs must read zero
   // immediately and across the rising edge. Pending requests are kept.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_stage = 0; m_ptr = 0;
      e_a = 0; e_b = 0; e_c = 0; e_s = 0; e_id = 0;
      e_rv = 0; e_rid = 0; e_data = 0; e_cout = 0; e_ovf = 0;
      e_ops = 0; e_ovfc = 0;
      check("rst_req_ready", req_ready, 0);
      check("rst_alu_op", {alu_a, alu_b, alu_cin, alu_s}, 0);
      check("rst_rsp", {rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_ovf}, 0);
`ifdef ALU_ARB_STATS_EN
      check("rst_stats", {stat_ops, stat_ovf}, 0);
`endif
      @(posedge clk);
      #1;
      check("rst_hold_rsp_valid", rsp_valid, 0);
      rst_n = 1'b1;
   endtask

   function automatic int n_pend();
      int n = 0;
      for (int i = 0; i < NREQ; i++) n += int'(pend[i]);
      return n;
   endfunction

   task automatic drain();
      int n = 0;
      while ((m_stage != 0 || n_pend() != 0) && n < 60) begin
         step();
         n++;
      end
      check("drain_stage", m_stage, 0);
      check("drain_pending", n_pend(), 0);
   endtask

   // --------------------------------------------------------------- stimulus --
   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      logic [31:0] snap;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pc[i] = 1'b0; ps[i] = '0;
      end
      cyc = 0;
      do_reset();

      // Single request from requester 1.
      set_req(1, 8'h7F, 8'h01, 0, 0);
      step();
      check("single_grant", req_ready, 4'b0010);
      step();
      check("single_exec_no_rsp", rsp_valid, 0);
      step();
      check("single_rsp_valid", rsp_valid, 1);
      check("single_rsp_id", rsp_id, 1);
      check("single_rsp_data", rsp_data, 8'h80);
      check("single_rsp_flags", {rsp_cout, rsp_ovf}, 2'b01);
      drain();

      // Round-robin with all requesters continuously valid.
      do_reset();
      g_log.delete();
      g_cyc.delete();
      for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, $urandom_range(1), $urandom_range(7));
      for (int t = 0; t < 15; t++) begin
         step();
         for (int i = 0; i < NREQ; i++)
            if (!pend[i]) set_req(i, $urandom, $urandom, $urandom_range(1), $urandom_range(7));
      end
      check("rr_count", g_log.size(), 5);
      for (int i = 0; i < 5 && i < g_log.size(); i++) begin
         check("rr_order", g_log[i], i % NREQ);
         if (i > 0) check("rr_interval", g_cyc[i] - g_cyc[i-1], 3);
      end
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      drain();

      // Carry-out case on requester 2.
      set_req(2, 8'hFF, 8'h01, 0, 0);
      step(); step(); step();
      check("carry_rsp_id", rsp_id, 2);
      check("carry_rsp_data", rsp_data, 8'h00);
      check("carry_rsp_flags", {rsp_cout, rsp_ovf}, 2'b10);
      drain();

      // Backpressure: response held for five cycles, other requests stalled.
      drv_rdy = 1'b0;
      set_req(3, $urandom, $urandom, $urandom_range(1), $urandom_range(7));
      n = 0;
      while (m_stage != 2 && n < 5) begin step(); n++; end
      set_req(0, $urandom, $urandom, $urandom_range(1), $urandom_range(7));
      step();
      snap = {19'd0, rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_ovf};
      check("bp_valid", rsp_valid, 1);
      for (int t = 0; t < 5; t++) begin
         step();
         check("bp_stable", {19'd0, rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_ovf}, snap);
         check("bp_no_grant", req_ready, 0);
      end
      drv_rdy = 1'b1;
      step();
      step();
      check("bp_resume_grant", req_ready, 4'b0001);
      drain();

      // Reset in the middle of an operation.
      set_req(1, $urandom, $urandom, $urandom_range(1), $urandom_range(7));
      step();
      set_req(0, $urandom, $urandom, $urandom_range(1), $urandom_range(7));
      set_req(2, $urandom, $urandom, $urandom_range(1), $urandom_range(7));
      do_reset();
      step();
      check("mid_reset_first_grant", req_ready, 4'b0001);
      drain();
      check("mid_reset_second_grant", g_log[g_log.size()-1], 2);

`ifdef ALU_ARB_STATS_EN
      // Statistics: three ops, one overflowing, then a clear on the fourth.
      do_reset();
      set_req(0, 8'h7F, 8'h01, 0, 0); drain();
      set_req(1, 8'h10, 8'h20, 0, 0); drain();
      set_req(2, 8'h01, 8'h01, 1, 0); drain();
      check("stats_ops_3", stat_ops, 3);
      check("stats_ovf_1", stat_ovf, 1);
      set_req(3, 8'h05, 8'h06, 0, 0);
      n = 0;
      while (m_stage != 2 && n < 5) begin step(); n++; end
      drv_clr = 1'b1;
      step();
      drv_clr = 1'b0;
      step();
      check("stats_clr_ops", stat_ops, 0);
      check("stats_clr_ovf", stat_ovf, 0);
      drain();
`endif

      // Randomized traffic with backpressure and early withdrawals.
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(2) == 0)
               set_req(i, $urandom, $urandom, $urandom_range(1), $urandom_range(7));
            else if (pend[i] && $urandom_range(19) == 0)
               pend[i] = 1'b0;
         end
         drv_rdy = ($urandom_range(3) != 0);
         drv_clr = ($urandom_range(49) == 0);
         step();
      end
      drv_rdy = 1'b1;
      drv_clr = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 8-bit ALU datapath among NREQ independent requesters using round-robin arbitration. Each accepted request is one ALU operation: operands A and B, carry-in Cin, and select S. The arbiter latches the operation and drives the ALU from registers. It captures Data/Cout/Overflow into a result register and returns the result with the requester ID over a valid/ready response channel. Sits between the sequencer/requester clients and the ALU instance.

Parameters:
NREQ, 4, number of requesters; legal range 2..8
IDW, clog2(NREQ), width of the requester ID (derived localparam, minimum 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_a  input  8*NREQ  operand A; slice i belongs to requester i
req_b  input  8*NREQ  operand B; slice i
req_cin  input  NREQ  carry-in; bit i
req_s  input  3*NREQ  ALU select; slice i
alu_a  output  8  to ALU A
alu_b  output  8  to ALU B
alu_cin  output  1  to ALU Cin
alu_s  output  3  to ALU S
alu_data  input  8  from ALU Data (combinational path)
alu_cout  input  1  from ALU Cout
alu_ovf  input  1  from ALU Overflow
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  IDW  index of the requester that issued the operation
rsp_data  output  8  captured ALU Data
rsp_cout  output  1  captured Cout
rsp_ovf  output  1  captured Overflow

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: all op and result registers are 0, so alu_a/alu_b/alu_cin/alu_s = 0. rsp_valid=0, rsp_id=0, rsp_data=0, rsp_cout=0, rsp_ovf=0. The round-robin pointer is 0, giving requester 0 top priority.
- IDLE:
  - The winner is the first set req_valid bit, scanning from the pointer upward and wrapping mod NREQ.
  - req_ready[winner]=1 is driven combinationally. It is only ever asserted in IDLE.
  - On the handshake, latch the winner's a/b/cin/s and its ID, set pointer = winner+1 mod NREQ, and go to EXEC.
  - If no valid bit is set, stay in IDLE and hold the pointer.
- EXEC: alu_* carry the latched operation. At the clock edge, capture alu_data/alu_cout/alu_ovf into the rsp registers, set rsp_valid=1, and go to RESP. The ALU is treated as purely combinational with a single-cycle path.
- RESP: rsp_* are held stable while rsp_valid=1. On rsp_valid&rsp_ready, clear rsp_valid and go to IDLE. rsp_ready may be asserted continuously.
- Latency: handshake edge to rsp_valid is 1 cycle. Minimum issue interval is 3 cycles when rsp_ready is held high.
- Requesters must hold valid and payload until ready. A requester that drops valid before it is granted is simply skipped.
- Fairness: with all NREQ valid continuously, grants follow 0,1,...,NREQ-1,0,... No requester waits more than NREQ-1 other grants.
- Simultaneous events: a new req_valid during EXEC/RESP is not accepted until IDLE. Response-channel backpressure stalls all requesters.
- rsp_data/rsp_cout/rsp_ovf keep their last captured value after rsp_valid falls. alu_* keep the last operation while in IDLE.
- Reset mid-operation (rst_n low in EXEC or RESP): the operation is discarded with no response, all outputs return to reset values immediately, and the pointer returns to 0.

Optional Feature:
- ALU_ARB_STATS_EN defined:
  - Adds input stat_clr (1 bit) and outputs stat_ops (16 bits) and stat_ovf (16 bits).
  - stat_ops increments on each response handshake. stat_ovf increments on each response handshake with rsp_ovf=1.
  - Both counters saturate at 0xFFFF, reset to 0, and are synchronously cleared by stat_clr.
  - If stat_clr coincides with a handshake, the clear wins.
- ALU_ARB_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
The bench stub ALU computes Data = A+B+Cin (8-bit), Cout = carry out, Overflow = signed overflow.
- Single request: req1 with A=0x7F, B=0x01, Cin=0, S=000; rsp_ready=1 -> req_ready=0010 for one cycle; rsp_valid one cycle later with rsp_id=1, rsp_data=0x80, rsp_cout=0, rsp_ovf=1.
- Round-robin: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 with one grant every 3 cycles. Then A=0xFF, B=0x01 for req2 -> rsp_data=0x00, rsp_cout=1, rsp_ovf=0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0 throughout. Releasing rsp_ready completes the handshake and re-enters IDLE.
- Reset mid-EXEC: rst_n low for 1 cycle during EXEC -> no response is produced, all outputs are 0, and requests 0 and 2 pending afterwards grant 0 first.
- Stats (ALU_ARB_STATS_EN): 3 ops, one overflowing -> stat_ops=3, stat_ovf=1. stat_clr coinciding with a 4th handshake -> both counters 0.
